// File: rtl/tc_multi_pkg.sv
// Shared constants for the multi-channel timer/counter: register offsets, counting modes,
// CTRL bit positions and the byte-lane helper used by the write path.
package tc_multi_pkg;

    localparam logic [1:0] TC_OFF_CTRL   = 2'd0;
    localparam logic [1:0] TC_OFF_PRESET = 2'd1;
    localparam logic [1:0] TC_OFF_COUNT  = 2'd2;
    localparam logic [1:0] TC_OFF_STAT   = 2'd3;

    typedef enum logic [1:0] {
        TC_MODE_ONESHOT = 2'b00,
        TC_MODE_RELOAD  = 2'b01,
        TC_MODE_FREERUN = 2'b10,
        TC_MODE_RSVD    = 2'b11
    } tc_mode_e;

    localparam int TC_CTRL_EN       = 0;
    localparam int TC_CTRL_MODE_LSB = 1;
    localparam int TC_CTRL_IM       = 3;
    localparam int TC_CTRL_PSC_LSB  = 8;

    function automatic logic [31:0] tc_byte_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/tc_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STAT registers, prescaler, down/free-run counter and
// the sticky PEND flag. Register reads are selected combinationally by rsel.
module tc_channel
    import tc_multi_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_ctrl,
    input  logic        we_preset,
    input  logic        we_stat,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    input  logic [1:0]  rsel,
    output logic [31:0] rdata,
    output logic        irq
);

    logic             en_q, en_d;
    tc_mode_e         mode_q, mode_d, mode_eff;
    logic             im_q, im_d;
    logic [PSC_W-1:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d;
    logic [CNT_W-1:0] preset_q, preset_d, count_q, count_d;
    logic             pend_q, pend_d;
    logic [31:0]      mask, ctrl_rd, ctrl_wr, preset_wr;
    logic             en_wr, tick, start, stop, evt;
    logic             unused_bits;

    assign mask = tc_byte_mask(be);

    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[TC_CTRL_EN]                   = en_q;
        ctrl_rd[TC_CTRL_MODE_LSB +: 2]        = mode_q;
        ctrl_rd[TC_CTRL_IM]                   = im_q;
        ctrl_rd[TC_CTRL_PSC_LSB +: PSC_W]     = psc_q;
    end

    assign ctrl_wr     = (ctrl_rd & ~mask) | (wd & mask);
    assign preset_wr   = (32'(preset_q) & ~mask) | (wd & mask);
    assign unused_bits = ^{ctrl_wr, preset_wr};

    // EN as the CPU leaves it this cycle; start/stop are edges of that value, not of events
    assign en_wr    = we_ctrl ? ctrl_wr[TC_CTRL_EN] : en_q;
    assign start    = !en_q && en_wr;
    assign stop     = en_q && !en_wr;
    assign tick     = en_q && (psc_cnt_q == psc_q);
    assign mode_eff = (mode_q == TC_MODE_RSVD) ? TC_MODE_ONESHOT : mode_q;

    always_comb begin
        en_d     = en_wr;
        mode_d   = mode_q;
        im_d     = im_q;
        psc_d    = psc_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;
        evt      = 1'b0;
        if (we_ctrl) begin
            mode_d = tc_mode_e'(ctrl_wr[TC_CTRL_MODE_LSB +: 2]);
            im_d   = ctrl_wr[TC_CTRL_IM];
            psc_d  = ctrl_wr[TC_CTRL_PSC_LSB +: PSC_W];
        end
        if (we_preset) begin
            preset_d = preset_wr[CNT_W-1:0];
        end
        if (start) begin
            count_d = preset_q;
        end else if (tick && !stop) begin
            if (mode_eff == TC_MODE_FREERUN) begin
                count_d = count_q + CNT_W'(1);
                evt     = &count_q;
            end else if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else begin
                evt = 1'b1;
                if (mode_eff == TC_MODE_RELOAD) begin
                    count_d = preset_q;
                end else if (!(we_ctrl && be[0])) begin
                    en_d = 1'b0;
                end
            end
        end
        psc_cnt_d = (!en_q || !en_d || tick) ? '0 : psc_cnt_q + PSC_W'(1);
        // A same-cycle event beats the W1C
        if (evt) begin
            pend_d = 1'b1;
        end else if (we_stat && be[0] && wd[0]) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            mode_q    <= TC_MODE_ONESHOT;
            im_q      <= 1'b0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            im_q      <= im_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (rsel)
            TC_OFF_CTRL:   rdata = ctrl_rd;
            TC_OFF_PRESET: rdata[CNT_W-1:0] = preset_q;
            TC_OFF_COUNT:  rdata[CNT_W-1:0] = count_q;
            default:       rdata[0] = pend_q;
        endcase
    end

    assign irq = pend_q & im_q;

endmodule

// File: rtl/tc_multi.sv
// N-channel programmable timer/counter slave: address decode, per-channel write strobes,
// combinational read mux and interrupt aggregation.
module tc_multi
    import tc_multi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          PSC_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wd,
    output logic [31:0]       rd,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [31:0]     off;
    logic            hit;
    logic [CH_W-1:0] ch_sel;
    logic [1:0]      word;
    logic [31:0]     rd_ch [NUM_CH];
    logic            unused_off;

    assign off        = addr - BASE_ADDR;
    assign hit        = (addr >= BASE_ADDR) && (off < 32'(NUM_CH * 16));
    assign ch_sel     = off[4 +: CH_W];
    assign word       = off[3:2];
    assign unused_off = ^off;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic sel;
        assign sel = we && hit && (ch_sel == CH_W'(k));

        tc_channel #(
            .CNT_W (CNT_W),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .we_ctrl   (sel && (word == TC_OFF_CTRL)),
            .we_preset (sel && (word == TC_OFF_PRESET)),
            .we_stat   (sel && (word == TC_OFF_STAT)),
            .be        (be),
            .wd        (wd),
            .rsel      (word),
            .rdata     (rd_ch[k]),
            .irq       (irq[k])
        );
    end

    always_comb begin
        rd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (hit && (ch_sel == CH_W'(k))) begin
                rd = rd_ch[k];
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_tc_multi.sv
// Bench for tc_multi (4 channels, 8-bit counters): directed timing scenarios plus random bus
// traffic, all checked against a register-level reference model.
module tb_tc_multi;

    localparam logic [31:0] BASE      = 32'h0000_7F00;
    localparam int          NCH       = 4;
    localparam int          CW        = 8;
    localparam int          PW        = 8;
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF0F;
    localparam logic [31:0] CNT_MASK  = 32'h0000_00FF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    addr = '0;
    logic           we = 1'b0;
    logic [3:0]     be = '0;
    logic [31:0]    wd = '0;
    logic [31:0]    rd;
    logic [NCH-1:0] irq;
    logic           irq_any;

    tc_multi #(
        .BASE_ADDR (BASE),
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .PSC_W     (PW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .be      (be),
        .wd      (wd),
        .rd      (rd),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [31:0] m_ctrl   [NCH];
    logic [31:0] m_preset [NCH];
    logic [31:0] m_count  [NCH];
    bit          m_pend   [NCH];
    int          m_pc     [NCH];

    function automatic logic [31:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_ctrl[k] = '0; m_preset[k] = '0; m_count[k] = '0; m_pend[k] = 0; m_pc[k] = 0;
        end
    endfunction

    function automatic void model_step();
        logic [31:0] off, m, nctrl, ncount, npre;
        bit in_rng, hit, was_en, tick, evt, cpu_en;
        int mode;
        off    = addr - BASE;
        in_rng = (addr >= BASE) && (off < NCH * 16);
        m      = lane_mask(be);
        for (int k = 0; k < NCH; k++) begin
            hit    = we && in_rng && (int'(off >> 4) == k);
            nctrl  = m_ctrl[k];
            ncount = m_count[k];
            npre   = m_preset[k];
            was_en = m_ctrl[k][0];
            tick   = was_en && (m_pc[k] == int'(m_ctrl[k][15:8]));
            mode   = int'(m_ctrl[k][2:1]);
            if (mode == 3) mode = 0;
            evt    = 0;
            cpu_en = hit && (off[3:2] == 2'd0) && be[0];
            if (hit && off[3:2] == 2'd0) nctrl = ((m_ctrl[k] & ~m) | (wd & m)) & CTRL_MASK;
            if (hit && off[3:2] == 2'd1) npre = ((m_preset[k] & ~m) | (wd & m)) & CNT_MASK;
            if (!was_en && nctrl[0]) begin
                ncount = m_preset[k];
            end else if (was_en && nctrl[0] && tick) begin
                if (mode == 2) begin
                    ncount = (m_count[k] + 1) % 256;
                    evt    = (m_count[k] == 255);
                end else if (m_count[k] != 0) begin
                    ncount = m_count[k] - 1;
                end else begin
                    evt = 1;
                    if (mode == 1) ncount = m_preset[k];
                    else if (!cpu_en) nctrl[0] = 1'b0;
                end
            end
            m_pc[k] = (!nctrl[0] || !was_en || tick) ? 0 : (m_pc[k] + 1) % 256;
            if (evt) m_pend[k] = 1;
            else if (hit && off[3:2] == 2'd3 && be[0] && wd[0]) m_pend[k] = 0;
            m_ctrl[k]   = nctrl;
            m_count[k]  = ncount;
            m_preset[k] = npre;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        int k;
        off = a - BASE;
        if (a < BASE || off >= NCH * 16) return '0;
        k = int'(off >> 4);
        case (off[3:2])
            2'd0:    return m_ctrl[k];
            2'd1:    return m_preset[k];
            2'd2:    return m_count[k];
            default: return {31'd0, m_pend[k]};
        endcase
    endfunction

    function automatic logic [31:0] model_irq();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k] = m_pend[k] & m_ctrl[k][3];
        return r;
    endfunction

    always @(posedge clk) if (!reset) model_step();

    // ---------------- checking and drivers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        addr = a; be = b; wd = d; we = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0; be = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        @(negedge clk);
        addr = a;
        #1;
        check(tag, rd, model_read(a));
    endtask

    task automatic irq_chk(input string tag);
        check(tag, 32'(irq), model_irq());
        check({tag, "_any"}, 32'(irq_any), 32'(|model_irq()));
    endtask

    task automatic sweep(input string tag);
        for (int k = 0; k < NCH; k++)
            for (int w = 0; w < 4; w++) rd_chk(tag, BASE + 32'(k * 16 + w * 4));
        irq_chk(tag);
    endtask

    task automatic wait_irq(input string tag, input int budget, output int c);
        int n;
        n = 0;
        while (!irq_any && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(irq_any), 32'd1);
        c = cyc;
    endtask

    task automatic poll_pend(input logic [31:0] a, input int budget, output int c);
        int n;
        n = 0;
        addr = a;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (rd[0]) break;
        end
        check("fr_pend", 32'(rd[0]), 32'd1);
        c = cyc;
    endtask

    // ---------------- scenarios ----------------
    task automatic t_oneshot();
        int cs, c;
        wr(BASE + 4, 4'hF, 32'd3);
        wr(BASE, 4'hF, 32'h0000_0009);
        cs = cyc;
        for (int i = 0; i < 4; i++) begin
            rd_chk("os_cnt_model", BASE + 8);
            check("os_cnt", rd, 32'(3 - i));
        end
        wait_irq("os_irq", 20, c);
        check("os_latency", 32'(c - cs), 32'd4);
        check("os_irq0", 32'(irq), 32'h1);
        rd_chk("os_ctrl", BASE);
        check("os_en_off", rd, 32'h0000_0008);
        for (int i = 0; i < 3; i++) rd_chk("os_hold", BASE + 8);
        check("os_hold0", rd, 32'd0);
        wr(BASE + 12, 4'h1, 32'd1);
        irq_chk("os_clr");
    endtask

    task automatic t_reload_and_race();
        int exp_p [4];
        int prev, c;
        exp_p[0] = 6; exp_p[1] = 6; exp_p[2] = 6; exp_p[3] = 12;
        wr(BASE + 16 + 4, 4'hF, 32'd2);
        wr(BASE + 16, 4'hF, 32'h0000_010B);
        prev = cyc;
        c = prev;
        for (int i = 0; i < 4; i++) begin
            wait_irq("ar_irq", 40, c);
            check($sformatf("ar_period%0d", i), 32'(c - prev), 32'(exp_p[i]));
            prev = c;
            wr(BASE + 16 + 12, 4'h1, 32'd1);
            if (i == 1) wr(BASE + 16 + 4, 4'hF, 32'd5);
        end
        // land the W1C exactly on the next reload event
        while (cyc < c + 11) @(negedge clk);
        wr(BASE + 16 + 12, 4'h1, 32'd1);
        rd_chk("race_stat_model", BASE + 16 + 12);
        check("race_pend", rd, 32'd1);
        check("race_irq1", 32'(irq[1]), 32'd1);
        wr(BASE + 16 + 12, 4'hF, 32'd0);
        rd_chk("w0_stat_model", BASE + 16 + 12);
        check("w0_keeps", rd, 32'd1);
        wr(BASE + 16 + 12, 4'h1, 32'd1);
        rd_chk("w1c_stat_model", BASE + 16 + 12);
        check("w1c_clears", rd, 32'd0);
        wr(BASE + 16, 4'hF, 32'd0);
        irq_chk("ar_stop");
    endtask

    task automatic t_freerun();
        int cs, c1, c2;
        wr(BASE + 32 + 4, 4'hF, 32'd0);
        wr(BASE + 32, 4'hF, 32'h0000_0005);
        cs = cyc;
        poll_pend(BASE + 32 + 12, 400, c1);
        check("fr_first", 32'(c1 - cs), 32'd256);
        check("fr_irq2_masked", 32'(irq[2]), 32'd0);
        check("fr_irq_any", 32'(irq_any), 32'd0);
        wr(BASE + 32 + 12, 4'h1, 32'd1);
        poll_pend(BASE + 32 + 12, 400, c2);
        check("fr_period", 32'(c2 - c1), 32'd256);
        wr(BASE + 32, 4'hF, 32'd0);
        wr(BASE + 32 + 12, 4'h1, 32'd1);
        sweep("fr_end");
    endtask

    task automatic t_bus();
        wr(BASE + 48 + 4, 4'b0001, 32'hFFFF_FFFF);
        rd_chk("bus_preset_model", BASE + 48 + 4);
        check("bus_preset", rd, 32'h0000_00FF);
        wr(BASE + 48 + 8, 4'hF, 32'h0000_0012);
        rd_chk("bus_count_model", BASE + 48 + 8);
        check("bus_count_ro", rd, 32'd0);
        wr(BASE + NCH * 16, 4'hF, 32'hFFFF_FFFF);
        wr(BASE + NCH * 16 + 4, 4'hF, 32'hFFFF_FFFF);
        rd_chk("bus_oor", BASE + NCH * 16);
        check("bus_oor0", rd, 32'd0);
        rd_chk("bus_below", BASE - 4);
        sweep("bus_nochange");
    endtask

    task automatic t_random();
        int ch, w;
        logic [31:0] a, d;
        for (int k = 0; k < NCH; k++) begin
            wr(BASE + 32'(k * 16 + 4), 4'hF, 32'($urandom_range(0, 9)));
            d = 32'h1 | (32'($urandom_range(0, 3)) << 1) | (32'($urandom_range(0, 1)) << 3)
                | (32'($urandom_range(0, 3)) << 8);
            wr(BASE + 32'(k * 16), 4'hF, d);
        end
        for (int i = 0; i < 400; i++) begin
            ch = $urandom_range(0, NCH);
            w  = $urandom_range(0, 3);
            a  = BASE + 32'(ch * 16 + w * 4);
            if ($urandom_range(0, 3) == 0) begin
                d = $urandom;
                if (w == 0) d[15:8] = 8'($urandom_range(0, 3));
                if (w == 1) d[7:0] = 8'($urandom_range(0, 9));
                wr(a, 4'($urandom_range(0, 15)), d);
            end else begin
                rd_chk("rnd_rd", a);
                irq_chk("rnd_irq");
            end
        end
    endtask

    task automatic t_reset_mid();
        wr(BASE + 4, 4'hF, 32'd100);
        wr(BASE, 4'hF, 32'h0000_0009);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_async_cnt0", rd, 32'd0);
        check("rst_async_irq", 32'(irq), 32'd0);
        repeat (2) rd_chk("rst_hold", BASE + 8);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rd_chk("rst_cnt_model", BASE + 8);
            check("rst_cnt0", rd, 32'd0);
        end
        sweep("rst_after");
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        sweep("reset_state");
        t_oneshot();
        t_reload_and_race();
        t_freerun();
        t_bus();
        t_random();
        t_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
